cv32e40s_lockstep_compare: RTL and testbench
============================================

Name: cv32e40s_lockstep_compare

Overview:
Multi-channel, time-shifted lockstep comparator for the cv32e40s dual-core setup. The master core's outputs are delayed DELAY cycles to align with the checker core, which runs DELAY cycles behind. Both are then compared per channel over the full channel width, with masking. The block counts mismatches, escalates to a sticky fatal error after THRESHOLD consecutive mismatching compare cycles, and holds the error until it is explicitly cleared.

Parameters:
N, 32, bits per channel (>=1)
CHANNELS, 4, number of compared channels (>=1)
DELAY, 2, master-to-checker skew in cycles (>=0; 0 means no delay line)
THRESHOLD, 1, consecutive mismatching compare cycles needed for fatal (>=1)
CNT_W, 8, mismatch counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  comparison enable
valid_i  in  1  master sample valid this cycle
master_i  in  CHANNELS*N  master core outputs; channel c = bits [c*N +: N]
checker_i  in  CHANNELS*N  checker core outputs, same packing
chan_mask_i  in  CHANNELS  1 = channel compared, 0 = ignored
clear_i  in  1  clear fault and counters (single-cycle pulse)
mismatch_o  out  CHANNELS  registered per-channel mismatch of the last compare cycle
error_o  out  1  sticky fatal lockstep error
error_chan_o  out  CHANNELS  mismatch vector captured on the cycle error_o set
mismatch_cnt_o  out  CNT_W  total mismatching compare cycles, saturating
state_o  out  2  FSM state: 0 IDLE, 1 WARMUP, 2 ACTIVE, 3 FAULT

Behaviour:
- Reset (async, rst_ni=0): all outputs 0. State is IDLE. Delay-line data and valid bits and the consecutive counter are 0.
- Delay line: DELAY-stage shift register of {valid_i, master_i}. It shifts every cycle, in every state except FAULT, where it holds. With DELAY=0 the master is used directly.
- Compare cycle: state ACTIVE and delayed valid=1. Checker_i sampled at cycle t is compared with master_i from cycle t-DELAY.
- Per-channel mismatch: chan_mask_i[c] & (any of the N bits differ). All N bits are compared, MSB included. Case inequality is used, so X/Z is a mismatch in simulation.
- Latency: master sample at t, checker at t+DELAY; mismatch_o is updated at the clock edge ending cycle t+DELAY and is visible in cycle t+DELAY+1.
- mismatch_o is written on compare cycles and cleared to 0 on non-compare cycles.
- Consecutive counter:
  - Any compare cycle with a mismatch: increment, saturating at THRESHOLD.
  - Compare cycle with no mismatch: reset to 0.
  - Non-compare cycle: hold.
- mismatch_cnt_o: +1 per compare cycle with a mismatch. Saturates at 2^CNT_W-1 with no wrap.
- FSM:
  - IDLE: enable_i=1 -> WARMUP, or ACTIVE if DELAY=0. The delay line is flushed (valid bits 0) while in IDLE.
  - WARMUP: lasts exactly DELAY cycles, then -> ACTIVE. No comparisons. enable_i=0 -> IDLE.
  - ACTIVE: enable_i=0 -> IDLE. The THRESHOLD-th consecutive mismatching compare cycle -> FAULT.
  - FAULT: error_o=1, held regardless of enable_i. Inputs are ignored and mismatch_o holds. Only clear_i leaves FAULT: -> WARMUP if enable_i=1 (or ACTIVE if DELAY=0), -> IDLE if enable_i=0.
- error_o and error_chan_o are set on the same edge as the mismatch_o update that reaches THRESHOLD, so they are visible in the same cycle as that mismatch_o.
- clear_i in any state: zeroes mismatch_cnt_o, the consecutive counter, mismatch_o, error_o and error_chan_o.
- clear_i in any state other than FAULT: the FSM is unchanged, except that the delay line is flushed.
- clear_i and a mismatch in the same cycle: clear wins and that cycle's mismatch is discarded.
- chan_mask_i is sampled on the compare cycle, not delayed. A fully masked compare cycle counts as a match.
- Mid-operation reset: asynchronous return to the reset state, with the FAULT condition lost.

Test Plan:
- N=32, CHANNELS=4, DELAY=2, THRESHOLD=1: drive identical streams skewed by 2 cycles for 20 valids -> mismatch_o=0, error_o=0, mismatch_cnt_o=0, state_o=2.
- Same setup, flip checker bit 31 of channel 3 on one compare cycle -> in the following cycle mismatch_o=4'b1000, error_o=1, error_chan_o=4'b1000, mismatch_cnt_o=1, state_o=3. The fault holds with enable_i toggling.
- THRESHOLD=3: mismatch, mismatch, match, mismatch, mismatch -> error_o stays 0 and mismatch_cnt_o=4. A third consecutive mismatch -> error_o=1.
- chan_mask_i=4'b1110 with a channel-0 difference -> no mismatch and no count. A channel-1 difference -> mismatch_o=4'b0010.
- In FAULT, pulse clear_i with enable_i=1 -> all counters and errors 0, state WARMUP for 2 cycles, then ACTIVE. Clear coincident with a mismatch -> count stays 0.
- CNT_W=2, THRESHOLD=8: 5 mismatching compare cycles -> mismatch_cnt_o saturates at 3. Assert rst_ni=0 mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/cv32e40s_lockstep_compare.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40s_lockstep_compare
// Brief    : Time-shifted multi-channel lockstep comparator with sticky fault.
// Revision : 1.0
// ============================================================================

module cv32e40s_lockstep_compare #(
   parameter int N         = 32,
   parameter int CHANNELS  = 4,
   parameter int DELAY     = 2,
   parameter int THRESHOLD = 1,
   parameter int CNT_W     = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic                  valid_i,
   input  logic [CHANNELS*N-1:0] master_i,
   input  logic [CHANNELS*N-1:0] checker_i,
   input  logic [CHANNELS-1:0]   chan_mask_i,
   input  logic                  clear_i,
   output logic [CHANNELS-1:0]   mismatch_o,
   output logic                  error_o,
   output logic [CHANNELS-1:0]   error_chan_o,
   output logic [CNT_W-1:0]      mismatch_cnt_o,
   output logic [1:0]            state_o
);

   localparam int W      = CHANNELS * N;
   localparam int CONS_W = $clog2(THRESHOLD + 1);
   localparam int WARM_W = (DELAY > 1) ? $clog2(DELAY) : 1;

   localparam logic [CONS_W-1:0] c_thresh    = CONS_W'(THRESHOLD);
   localparam logic [WARM_W-1:0] c_warm_last = (DELAY > 0) ? WARM_W'(DELAY - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WARM_W-1:0]   r_warm_cnt;
   logic [CONS_W-1:0]   r_consec;
   logic [CONS_W-1:0]   w_consec_inc;
   logic [CHANNELS-1:0] r_mismatch;
   logic                r_error;
   logic [CHANNELS-1:0] r_error_chan;
   logic [CNT_W-1:0]    r_mismatch_cnt;

   logic                w_dly_valid;
   logic [W-1:0]        w_dly_data;
   logic [CHANNELS-1:0] w_mis;
   logic                w_cmp;
   logic                w_any;
   logic                w_fault;
   logic                w_flush;

   assign w_flush = (r_state == ST_IDLE) | clear_i;

   // Stage 0 takes the live master sample; stage DELAY-1 lines up with the checker.
   generate
      if (DELAY > 0) begin : g_dly
         logic [W:0] r_line [DELAY];

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int i = 0; i < DELAY; i++) r_line[i] <= '0;
            end else if (w_flush) begin
               for (int i = 0; i < DELAY; i++) r_line[i] <= '0;
            end else if (r_state != ST_FAULT) begin
               r_line[0] <= {valid_i, master_i};
               for (int i = 1; i < DELAY; i++) r_line[i] <= r_line[i-1];
            end
         end

         assign w_dly_valid = r_line[DELAY-1][W];
         assign w_dly_data  = r_line[DELAY-1][W-1:0];
      end else begin : g_nodly
         assign w_dly_valid = valid_i;
         assign w_dly_data  = master_i;
      end
   endgenerate

   always_comb begin
      w_mis = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_mis[c] = chan_mask_i[c] & (checker_i[c*N +: N] !== w_dly_data[c*N +: N]);
      end
   end

   assign w_cmp        = (r_state == ST_ACTIVE) & w_dly_valid;
   assign w_any        = |w_mis;
   assign w_consec_inc = (r_consec < c_thresh) ? r_consec + CONS_W'(1) : c_thresh;
   // A same-cycle clear discards the mismatch, so it can never raise the fault.
   assign w_fault      = w_cmp & w_any & ~clear_i & (w_consec_inc == c_thresh);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable_i) w_state_nxt = (DELAY == 0) ? ST_ACTIVE : ST_WARMUP;
         end
         ST_WARMUP: begin
            if (!enable_i)                       w_state_nxt = ST_IDLE;
            else if (r_warm_cnt == c_warm_last)  w_state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (w_fault)        w_state_nxt = ST_FAULT;
            else if (!enable_i) w_state_nxt = ST_IDLE;
         end
         ST_FAULT: begin
            if (clear_i) begin
               if (enable_i) w_state_nxt = (DELAY == 0) ? ST_ACTIVE : ST_WARMUP;
               else          w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_warm_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_warm_cnt <= (r_state == ST_WARMUP && w_state_nxt == ST_WARMUP) ?
                       r_warm_cnt + WARM_W'(1) : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mismatch     <= '0;
         r_error        <= 1'b0;
         r_error_chan   <= '0;
         r_mismatch_cnt <= '0;
         r_consec       <= '0;
      end else if (clear_i) begin
         r_mismatch     <= '0;
         r_error        <= 1'b0;
         r_error_chan   <= '0;
         r_mismatch_cnt <= '0;
         r_consec       <= '0;
      end else if (r_state != ST_FAULT) begin
         if (w_cmp) begin
            r_mismatch <= w_mis;
            if (w_any) begin
               r_consec <= w_consec_inc;
               if (r_mismatch_cnt != '1) r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
            end else begin
               r_consec <= '0;
            end
            if (w_fault) begin
               r_error      <= 1'b1;
               r_error_chan <= w_mis;
            end
         end else begin
            r_mismatch <= '0;
         end
      end
   end

   assign mismatch_o     = r_mismatch;
   assign error_o        = r_error;
   assign error_chan_o   = r_error_chan;
   assign mismatch_cnt_o = r_mismatch_cnt;
   assign state_o        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40s_lockstep_compare.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40s_lockstep_compare
// Brief    : Three comparator configurations on one shared directed stream.
// Revision : 1.0
// ============================================================================

module tb_cv32e40s_lockstep_compare;

   localparam int S_IDLE = 0, S_WRM = 1, S_ACT = 2, S_FLT = 3;
   localparam int DLY = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable, valid, clear;
   logic [127:0] mst_data, chk_data;
   logic [3:0]   mask;

   logic [3:0] mis_a, mis_b, mis_c, ech_a, ech_b, ech_c;
   logic       err_a, err_b, err_c;
   logic [7:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;
   logic [1:0] st_a, st_b, st_c;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cv32e40s_lockstep_compare #(.N(32), .CHANNELS(4), .DELAY(2), .THRESHOLD(1), .CNT_W(8)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .valid_i(valid),
      .master_i(mst_data), .checker_i(chk_data), .chan_mask_i(mask), .clear_i(clear),
      .mismatch_o(mis_a), .error_o(err_a), .error_chan_o(ech_a),
      .mismatch_cnt_o(cnt_a), .state_o(st_a));

   cv32e40s_lockstep_compare #(.N(32), .CHANNELS(4), .DELAY(2), .THRESHOLD(3), .CNT_W(8)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .valid_i(valid),
      .master_i(mst_data), .checker_i(chk_data), .chan_mask_i(mask), .clear_i(clear),
      .mismatch_o(mis_b), .error_o(err_b), .error_chan_o(ech_b),
      .mismatch_cnt_o(cnt_b), .state_o(st_b));

   cv32e40s_lockstep_compare #(.N(32), .CHANNELS(4), .DELAY(2), .THRESHOLD(8), .CNT_W(2)) dut_c (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .valid_i(valid),
      .master_i(mst_data), .checker_i(chk_data), .chan_mask_i(mask), .clear_i(clear),
      .mismatch_o(mis_c), .error_o(err_c), .error_chan_o(ech_c),
      .mismatch_cnt_o(cnt_c), .state_o(st_c));

   function automatic int th_of(int k);
      return (k == 0) ? 1 : (k == 1) ? 3 : 8;
   endfunction

   function automatic int cmax_of(int k);
      return (k == 2) ? 3 : 255;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
      else             n_pass++;
   endtask

   // ---------------- reference model (one per configuration) ----------------
   int           m_st   [3];
   int           m_cons [3];
   int           m_cnt  [3];
   int           m_warm [3];
   logic [3:0]   m_mis  [3];
   logic         m_err  [3];
   logic [3:0]   m_ech  [3];
   logic [128:0] m_dl   [3][DLY];  // [0] newest sample, [DLY-1] aligned with checker

   always @(posedge clk or negedge rst_n) begin : model
      logic [128:0] old;
      logic [3:0]   mis;
      bit           cmp, fault;
      int           nc, ns;
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            m_st[k] <= S_IDLE; m_cons[k] <= 0; m_cnt[k] <= 0; m_warm[k] <= 0;
            m_mis[k] <= '0; m_err[k] <= 1'b0; m_ech[k] <= '0;
            for (int s = 0; s < DLY; s++) m_dl[k][s] <= '0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            old = m_dl[k][DLY-1];
            cmp = (m_st[k] == S_ACT) && old[128];
            mis = '0;
            for (int c = 0; c < 4; c++)
               if (mask[c] && (chk_data[c*32 +: 32] != old[c*32 +: 32])) mis[c] = 1'b1;
            nc    = (m_cons[k] + 1 > th_of(k)) ? th_of(k) : m_cons[k] + 1;
            fault = cmp && (mis != 0) && !clear && (nc == th_of(k));

            if (clear) begin
               m_mis[k] <= '0; m_err[k] <= 1'b0; m_ech[k] <= '0; m_cnt[k] <= 0; m_cons[k] <= 0;
            end else if (m_st[k] != S_FLT) begin
               if (cmp) begin
                  m_mis[k] <= mis;
                  if (mis != 0) begin
                     m_cons[k] <= nc;
                     m_cnt[k]  <= (m_cnt[k] >= cmax_of(k)) ? cmax_of(k) : m_cnt[k] + 1;
                  end else begin
                     m_cons[k] <= 0;
                  end
                  if (fault) begin m_err[k] <= 1'b1; m_ech[k] <= mis; end
               end else begin
                  m_mis[k] <= '0;
               end
            end

            ns = m_st[k];
            case (m_st[k])
               S_IDLE: if (enable) ns = S_WRM;
               S_WRM:  if (!enable) ns = S_IDLE; else if (m_warm[k] + 1 == DLY) ns = S_ACT;
               S_ACT:  if (fault) ns = S_FLT; else if (!enable) ns = S_IDLE;
               default: if (clear) ns = enable ? S_WRM : S_IDLE;
            endcase
            m_warm[k] <= (m_st[k] == S_WRM && ns == S_WRM) ? m_warm[k] + 1 : 0;

            if (m_st[k] == S_IDLE || clear) begin
               for (int s = 0; s < DLY; s++) m_dl[k][s] <= '0;
            end else if (m_st[k] != S_FLT) begin
               m_dl[k][0] <= {valid, mst_data};
               for (int s = 1; s < DLY; s++) m_dl[k][s] <= m_dl[k][s-1];
            end
            m_st[k] <= ns;
         end
      end
   end

   // ---------------- per-cycle comparison against the model -----------------
   always @(negedge clk) begin : compare
      logic [3:0] d_mis [3];
      logic [3:0] d_ech [3];
      logic       d_err [3];
      logic [7:0] d_cnt [3];
      logic [1:0] d_st  [3];
      d_mis[0] = mis_a; d_mis[1] = mis_b; d_mis[2] = mis_c;
      d_ech[0] = ech_a; d_ech[1] = ech_b; d_ech[2] = ech_c;
      d_err[0] = err_a; d_err[1] = err_b; d_err[2] = err_c;
      d_cnt[0] = cnt_a; d_cnt[1] = cnt_b; d_cnt[2] = {6'b0, cnt_c};
      d_st[0]  = st_a;  d_st[1]  = st_b;  d_st[2]  = st_c;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("model mismatch[%0d]", k), 128'(d_mis[k]), 128'(m_mis[k]));
         chk($sformatf("model error[%0d]", k),    128'(d_err[k]), 128'(m_err[k]));
         chk($sformatf("model err_chan[%0d]", k), 128'(d_ech[k]), 128'(m_ech[k]));
         chk($sformatf("model count[%0d]", k),    128'(d_cnt[k]), 128'(m_cnt[k]));
         chk($sformatf("model state[%0d]", k),    128'(d_st[k]),  128'(m_st[k]));
      end
   end

   // ---------------- stimulus ----------------
   int           n_smp = 0;
   logic [127:0] h1 = '0, h2 = '0;  // master samples from one and two cycles ago

   function automatic logic [127:0] bit_of(int b);
      logic [127:0] v;
      v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   task automatic drive(input bit vld, input logic [127:0] flip, input logic [3:0] msk,
                        input bit en, input bit clr);
      logic [127:0] m;
      for (int c = 0; c < 4; c++) m[c*32 +: 32] = 32'(n_smp) * 32'h9E3779B1 + 32'(c) * 32'h01234567;
      mst_data = m;
      chk_data = h2 ^ flip;
      valid    = vld;
      mask     = msk;
      enable   = en;
      clear    = clr;
      h2 = h1;
      h1 = m;
      n_smp++;
      @(negedge clk);
   endtask

   task automatic run(input int cycles, input bit en);
      for (int i = 0; i < cycles; i++) drive(1'b1, '0, 4'hF, en, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; valid = 1'b0; clear = 1'b0;
      mst_data = '0; chk_data = '0; mask = 4'hF;
      run(3, 1'b0);
      chk("reset mismatch", 128'(mis_a), 0);
      chk("reset error",    128'(err_a), 0);
      chk("reset state",    128'(st_a),  0);
      chk("reset count",    128'(cnt_a), 0);
      rst_n = 1'b1;
      run(2, 1'b0);

      run(25, 1'b1);
      chk("stream state",    128'(st_a),  2);
      chk("stream mismatch", 128'(mis_a), 0);
      chk("stream count",    128'(cnt_a), 0);

      drive(1'b1, bit_of(127), 4'hF, 1'b1, 1'b0);
      chk("msb flip mismatch", 128'(mis_a), 4'b1000);
      chk("msb flip error",    128'(err_a), 1);
      chk("msb flip err_chan", 128'(ech_a), 4'b1000);
      chk("msb flip count",    128'(cnt_a), 1);
      chk("msb flip state",    128'(st_a),  3);
      chk("th3 first state",   128'(st_b),  2);

      drive(1'b1, bit_of(64), 4'hF, 1'b1, 1'b0);
      drive(1'b1, '0,         4'hF, 1'b1, 1'b0);
      drive(1'b1, bit_of(7),  4'hF, 1'b1, 1'b0);
      drive(1'b1, bit_of(47), 4'hF, 1'b1, 1'b0);
      chk("th3 broken run error", 128'(err_b), 0);
      chk("th3 broken run count", 128'(cnt_b), 4);
      drive(1'b1, bit_of(127), 4'hF, 1'b1, 1'b0);
      chk("th3 third error",  128'(err_b), 1);
      chk("th3 third state",  128'(st_b),  3);
      chk("cntw2 saturation", 128'(cnt_c), 3);
      chk("th8 no error",     128'(err_c), 0);

      run(3, 1'b0);
      chk("fault hold state", 128'(st_a),  3);
      chk("fault hold error", 128'(err_a), 1);
      chk("disable to idle",  128'(st_c),  0);
      run(4, 1'b1);
      chk("fault hold state en", 128'(st_a), 3);
      chk("re-enable active",    128'(st_c), 2);

      drive(1'b1, '0, 4'hF, 1'b1, 1'b1);
      chk("clear state",    128'(st_a),  1);
      chk("clear error",    128'(err_a), 0);
      chk("clear err_chan", 128'(ech_a), 0);
      chk("clear count",    128'(cnt_a), 0);
      chk("clear active c", 128'(st_c),  2);
      run(1, 1'b1);
      chk("warmup second cycle", 128'(st_a), 1);
      run(1, 1'b1);
      chk("warmup done", 128'(st_a), 2);
      run(2, 1'b1);

      drive(1'b1, bit_of(5), 4'b1110, 1'b1, 1'b0);
      chk("masked ch0 mismatch", 128'(mis_a), 0);
      chk("masked ch0 count",    128'(cnt_a), 0);
      drive(1'b1, bit_of(41), 4'b1110, 1'b1, 1'b0);
      chk("unmasked ch1 mismatch", 128'(mis_a), 4'b0010);
      chk("unmasked ch1 error",    128'(err_a), 1);

      drive(1'b1, bit_of(41), 4'hF, 1'b1, 1'b1);
      chk("clear vs mismatch count",    128'(cnt_b), 0);
      chk("clear vs mismatch mismatch", 128'(mis_b), 0);
      run(4, 1'b1);

      drive(1'b0, '0,         4'hF, 1'b1, 1'b0);
      drive(1'b1, bit_of(64), 4'hF, 1'b1, 1'b0);
      drive(1'b1, bit_of(64), 4'hF, 1'b1, 1'b0);
      chk("invalid slot mismatch", 128'(mis_b), 0);
      drive(1'b1, bit_of(64), 4'hF, 1'b1, 1'b0);
      drive(1'b1, bit_of(64), 4'hF, 1'b1, 1'b0);
      chk("consec held over gap", 128'(err_b), 1);
      run(3, 1'b1);

      #2 rst_n = 1'b0;
      #1;
      chk("async reset state a", 128'(st_a),  0);
      chk("async reset error b", 128'(err_b), 0);
      chk("async reset count c", 128'(cnt_c), 0);
      chk("async reset err_chan b", 128'(ech_b), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(3, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
